timer_multi: RTL and testbench

Parametrised multi-channel successor to the single-channel enable-gated cycle timer. It provides CHANNELS independent WIDTH-bit counters that share a common prescaler. Each channel has its own enable, synchronous clear, compare value and mode: wrap, saturate, one-shot or periodic. It sits beside the existing timer in the multiple-clock test environment and feeds compare-match pulses and counts to display and measurement logic in the same clock domain.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_chan.sv | 116 +++++++++++
 rtl/timer_multi.sv | 72 +++++++
 tb/tb_timer_multi.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: mode encodings,
// default sizes and the config-address width helper.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_PERIODIC = 2'b11
  } mode_e;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_PRE_W    = 8;

  // A single channel still gets a 1-bit address so the port never collapses.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One timer channel: count, enable delay, config registers and the
// mode-dependent match/done logic. Advances only when eligible_o-style gating holds.
module timer_chan
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             cfg_we_i,
  input  mode_e            cfg_mode_i,
  input  logic [WIDTH-1:0] cfg_cmp_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             valid_o,
  output logic             match_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  mode_e            mode_q, mode_d;
  logic             en_d_q;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] nxt;
  logic             elig;

  assign nxt  = cnt_q + ONE;
  // The enable must have been high on the previous edge too.
  assign elig = en_i && en_d_q && tick_i;

  always_comb begin
    cnt_d   = cnt_q;
    done_d  = done_q;
    match_d = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (elig) begin
      unique case (mode_q)
        MODE_WRAP: begin
          cnt_d   = nxt;
          match_d = (nxt == cmp_q);
        end
        MODE_SAT: begin
          if (cnt_q != '1) begin
            cnt_d   = nxt;
            match_d = (nxt == cmp_q);
          end
        end
        MODE_ONESHOT: begin
          if (!done_q) begin
            if (cnt_q == cmp_q) begin
              done_d  = 1'b1;
              match_d = 1'b1;
            end else begin
              cnt_d = nxt;
              if (nxt == cmp_q) begin
                done_d  = 1'b1;
                match_d = 1'b1;
              end
            end
          end
        end
        MODE_PERIODIC: begin
          if (cnt_q >= cmp_q) begin
            cnt_d   = '0;
            match_d = 1'b1;
          end else begin
            cnt_d = nxt;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // A config write lands at the edge, so this cycle's increment still sees the old values.
  always_comb begin
    mode_d = mode_q;
    cmp_d  = cmp_q;
    if (cfg_we_i) begin
      mode_d = cfg_mode_i;
      cmp_d  = cfg_cmp_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      cmp_q   <= '1;
      mode_q  <= MODE_WRAP;
      en_d_q  <= 1'b0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      mode_q  <= mode_d;
      en_d_q  <= en_i;
      match_q <= match_d;
      done_q  <= done_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign valid_o = en_d_q;
  assign match_o = match_q;
  assign done_o  = done_q;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel cycle timer: shared prescaler, config address decode and
// an array of independent timer_chan instances.
module timer_multi
  import timer_pkg::*;
#(
  parameter  int CHANNELS = DEF_CHANNELS,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int PRE_W    = DEF_PRE_W,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [PRE_W-1:0]          prescale,
  input  logic [CHANNELS-1:0]       t_en,
  input  logic [CHANNELS-1:0]       t_clr,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [WIDTH-1:0]          cfg_cmp,
  output logic [CHANNELS-1:0]       t_valid,
  output logic [CHANNELS*WIDTH-1:0] t_out,
  output logic [CHANNELS-1:0]       t_match,
  output logic [CHANNELS-1:0]       t_done
);

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0]                pre_cnt_q, pre_cnt_d;
  logic                            tick;
  logic [CHANNELS-1:0]             cfg_sel;
  logic [CHANNELS-1:0][WIDTH-1:0]  cnt;

  // >= rather than == so lowering prescale mid-period cannot strand the counter.
  always_comb begin
    tick      = (pre_cnt_q >= prescale);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_ONE;
  end

  always_ff @(posedge clock) begin
    if (!reset) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end

  // Addresses at or beyond CHANNELS match no instance and are dropped.
  always_comb begin
    cfg_sel = '0;
    for (int k = 0; k < CHANNELS; k++)
      cfg_sel[k] = cfg_we && (int'(cfg_ch) == k);
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .tick_i     (tick),
      .en_i       (t_en[k]),
      .clr_i      (t_clr[k]),
      .cfg_we_i   (cfg_sel[k]),
      .cfg_mode_i (mode_e'(cfg_mode)),
      .cfg_cmp_i  (cfg_cmp),
      .cnt_o      (cnt[k]),
      .valid_o    (t_valid[k]),
      .match_o    (t_match[k]),
      .done_o     (t_done[k])
    );
  end

  assign t_out = cnt;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: stimulus pushes hand-derived expectations
// tagged with the edge they refer to; a monitor checks them after that edge.
module tb_timer_multi;

  localparam int CH = 5;
  localparam int W  = 4;
  localparam int PW = 8;
  localparam int CW = 3;

  logic          clock;
  logic          reset;
  logic [PW-1:0] prescale;
  logic [CH-1:0] t_en, t_clr;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_mode;
  logic [W-1:0]  cfg_cmp;
  logic [CH-1:0] t_valid, t_match, t_done;
  logic [CH*W-1:0] t_out;

  timer_multi #(.CHANNELS(CH), .WIDTH(W), .PRE_W(PW)) dut (
    .clock(clock), .reset(reset), .prescale(prescale), .t_en(t_en), .t_clr(t_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_cmp(cfg_cmp),
    .t_valid(t_valid), .t_out(t_out), .t_match(t_match), .t_done(t_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    string       name;
    int          ch;
    logic [W-1:0] cnt;
    logic        m, d, v;
  } exp_t;

  exp_t sbq[$];
  int   cyc_n    = 0;
  int   checks   = 0;
  int   failures = 0;

  int en1 [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int cnt1[11] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 5, 6};

  always @(posedge clock) cyc_n <= cyc_n + 1;

  // Monitor: compare every expectation whose edge has now happened.
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc_n) begin
      exp_t e;
      logic [W-1:0] a_cnt;
      e = sbq.pop_front();
      a_cnt = t_out[e.ch*W +: W];
      checks++;
      if (a_cnt !== e.cnt || t_match[e.ch] !== e.m || t_done[e.ch] !== e.d ||
          t_valid[e.ch] !== e.v) begin
        failures++;
        $display("FAIL %s ch%0d cyc%0d: got cnt=%0d match=%b done=%b valid=%b, want cnt=%0d match=%b done=%b valid=%b",
                 e.name, e.ch, e.cyc, a_cnt, t_match[e.ch], t_done[e.ch], t_valid[e.ch],
                 e.cnt, e.m, e.d, e.v);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expectation for the state visible after the next edge.
  task automatic expc(input string nm, input int ch, input int cnt, input bit m,
                      input bit d, input bit v);
    exp_t e;
    e.cyc = cyc_n + 1; e.name = nm; e.ch = ch; e.cnt = W'(cnt);
    e.m = m; e.d = d; e.v = v;
    sbq.push_back(e);
  endtask

  task automatic cfg(input int ch, input int mode, input int cmp);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_mode = 2'(mode); cfg_cmp = W'(cmp);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic run_oneshot();
    for (int i = 1; i <= 10; i++) begin
      t_en = 5'b00100;
      expc("oneshot", 2, (i - 1 > 5) ? 5 : i - 1, i == 6, i >= 6, 1'b1);
      step();
    end
  endtask

  initial begin
    reset = 1'b0; prescale = '0; t_en = '0; t_clr = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_cmp = '0;
    step();
    for (int c = 0; c < CH; c++) expc("reset", c, 0, 0, 0, 0);
    step();
    reset = 1'b1;

    // hold / resume on ch0
    for (int i = 0; i < 11; i++) begin
      t_en[0] = en1[i][0];
      expc("hold", 0, cnt1[i], 0, 0, en1[i][0]);
      step();
    end
    t_en = '0;

    // wrap vs saturate, cmp=3
    t_clr = 5'b00001;
    cfg_we = 1'b1; cfg_ch = 0; cfg_mode = 2'b00; cfg_cmp = 4'd3;
    expc("clr_cfg", 0, 0, 0, 0, 0);
    step();
    cfg_we = 1'b0; t_clr = '0;
    cfg(1, 1, 3);
    for (int i = 1; i <= 20; i++) begin
      t_en = 5'b00011;
      expc("wrap", 0, (i - 1) % 16, ((i - 1) % 16) == 3, 0, 1);
      expc("sat", 1, (i - 1 > 15) ? 15 : i - 1, i == 4, 0, 1);
      step();
    end
    t_en = '0;
    step();

    // one-shot, clear, re-run
    cfg(2, 2, 5);
    run_oneshot();
    t_en = '0; t_clr = 5'b00100;
    expc("os_clr", 2, 0, 0, 0, 0);
    step();
    t_clr = '0;
    run_oneshot();
    t_en = '0;
    step();

    // periodic with prescale=3: tick on every 4th edge
    cfg(3, 3, 2);
    prescale = 8'd3;
    for (int i = 1; i <= 26; i++) begin
      t_en = 5'b01000;
      expc("periodic", 3, (i / 4) % 3, (i % 4 == 0) && ((i / 4) % 3 == 0), 0, 1);
      step();
    end
    t_en = '0; prescale = '0;
    step();

    // simultaneous events on ch0, ch4 watches for stray config writes
    t_en = 5'b10001;
    expc("sim_start", 0, 3, 0, 0, 1); expc("ch4", 4, 0, 0, 0, 1);
    step();
    expc("sim_inc", 0, 4, 0, 0, 1);
    step();
    t_clr = 5'b00001;
    expc("clr_tick", 0, 0, 0, 0, 1);
    step();
    t_clr = '0;
    expc("after_clr", 0, 1, 0, 0, 1);
    step();
    cfg_we = 1'b1; cfg_ch = 0; cfg_mode = 2'b00; cfg_cmp = 4'd2;
    expc("cfg_old", 0, 2, 0, 0, 1);
    step();
    cfg_we = 1'b0;
    expc("cfg_new", 0, 3, 0, 0, 1);
    step();
    cfg_we = 1'b1; cfg_ch = 3'd5; cfg_mode = 2'b11; cfg_cmp = 4'd0;
    expc("bad_ch_edge", 0, 4, 0, 0, 1);
    step();
    cfg_we = 1'b0;
    expc("bad_ch0", 0, 5, 0, 0, 1); expc("bad_ch4", 4, 7, 0, 0, 1);
    step();
    expc("bad_ch0b", 0, 6, 0, 0, 1); expc("bad_ch4b", 4, 8, 0, 0, 1);
    step();

    // reset mid-count with prescaler part-way through a period
    prescale = 8'd3; t_en = 5'b11111;
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < CH; c++) expc("rst_mid", c, 0, 0, 0, 0);
    step();
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      for (int c = 0; c < CH; c++) expc("rst_pre", c, (i == 4) ? 1 : 0, 0, 0, 1);
      step();
    end
    prescale = '0;
    for (int j = 5; j <= 19; j++) begin
      for (int c = 0; c < CH; c++)
        expc("rst_cfg", c, (j - 3) % 16, ((j - 3) % 16) == 15, 0, 1);
      step();
    end
    t_en = '0;
    step();
    step();

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
